// File: rtl/imem_loader.sv
// Program loader: frames a byte stream into big-endian 32-bit words, writes them to
// instruction memory at consecutive word addresses and releases the core on a good checksum.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_LEN_HI | idle / waiting for word-count high byte; new frame restarts here
// S_LEN_LO | word-count low byte; range-checked against memory capacity
// S_DATA   | collecting the four bytes of the current word, MSB first
// S_WRITE  | one-cycle memory write, input stream stalled
// S_CSUM   | trailing XOR checksum byte compared against running value
module imem_loader #(
  parameter int ASIZE     = 32,
  parameter int DSIZE     = 32,
  parameter int BASE_ADDR = 0,
  parameter int MEM_WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_wen,
  output logic [ASIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_data,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             load_err
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM
  } state_t;

  localparam logic [31:0]      CAPACITY  = 32'(MEM_WORDS - BASE_ADDR);
  localparam logic [ASIZE-1:0] ADDR_BASE = ASIZE'(BASE_ADDR);

  state_t      state, state_nxt;
  logic [7:0]  len_hi;
  logic [7:0]  csum;
  logic [15:0] words_left;
  logic [1:0]  byte_cnt;
  logic        accept;
  logic [15:0] len_n;
  logic        len_too_big;

  assign in_ready    = (state != S_WRITE);
  assign accept      = in_valid && in_ready;
  assign len_n       = {len_hi, in_data};
  assign len_too_big = {16'd0, len_n} > CAPACITY;

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_too_big)        state_nxt = S_LEN_HI;
          else if (len_n == 16'd0) state_nxt = S_CSUM;
          else                     state_nxt = S_DATA;
        end
      end
      S_DATA:   if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = (words_left == 16'd1) ? S_CSUM : S_DATA;
      S_CSUM:   if (accept) state_nxt = S_LEN_HI;
      default:  state_nxt = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LEN_HI;
      len_hi     <= 8'd0;
      csum       <= 8'd0;
      words_left <= 16'd0;
      byte_cnt   <= 2'd0;
      mem_wen    <= 1'b0;
      mem_addr   <= ADDR_BASE;
      mem_data   <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_wen   <= (state_nxt == S_WRITE);
      load_done <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        S_LEN_HI: begin
          if (accept) begin
            len_hi   <= in_data;
            csum     <= in_data;
            cpu_hold <= 1'b1;
            mem_addr <= ADDR_BASE;
            byte_cnt <= 2'd0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            words_left <= len_n;
            if (len_too_big) begin
              load_err <= 1'b1;
              csum     <= 8'd0;
            end else begin
              csum <= csum ^ in_data;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            // mem_data doubles as the word assembly register; wen is low meanwhile
            mem_data <= {mem_data[DSIZE-9:0], in_data};
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          words_left <= words_left - 16'd1;
          // hold the last address so it never runs past the final word
          if (words_left != 16'd1) mem_addr <= mem_addr + ASIZE'(1);
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == csum) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_err <= 1'b1;
            end
            csum <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames driven through the byte handshake,
// memory writes checked against a scoreboard queue, plus hand-written corner sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  imem_loader #(.ASIZE(32), .DSIZE(32), .BASE_ADDR(0), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_data(mem_data), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [3:0][31:0] words;
    bit               corrupt;
    bit               gaps;
    bit               exp_done;
    bit               exp_err;
    bit               exp_hold;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int wr_cnt     = 0;
  int done_cnt   = 0;
  int err_cnt    = 0;
  int done_cyc   = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pop on each write, pulse bookkeeping
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wen) begin
        logic [63:0] e;
        wr_cnt++;
        check("ready_low_on_write", {63'd0, in_ready}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", {32'd0, mem_addr}, {32'd0, e[63:32]});
          check("write_data", {32'd0, mem_data}, {32'd0, e[31:0]});
        end
      end else if (!in_ready) begin
        check("ready_low_without_write", {63'd0, in_ready}, 64'd1);
      end
      if (load_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (prev_done) check("done_pulse_width", 64'd2, 64'd1);
      end
      if (load_err) begin
        err_cnt++;
        if (prev_err) check("err_pulse_width", 64'd2, 64'd1);
      end
    end
    prev_done = load_done;
    prev_err  = load_err;
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    if (gaps) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("byte_accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] cs;
    int wr0, dn0, er0, t0;
    wr0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
    cs = v.n[15:8] ^ v.n[7:0];
    send_byte(v.n[15:8], v.gaps);
    t0 = cyc;
    check({tag, "_hold_after_len_hi"}, {63'd0, cpu_hold}, 64'd1);
    send_byte(v.n[7:0], v.gaps);
    for (int w = 0; w < v.n; w++) begin
      exp_q.push_back({32'(w), v.words[w]});
      for (int k = 3; k >= 0; k--) begin
        logic [31:0] word;
        word = v.words[w];
        cs = cs ^ word[8*k +: 8];
        send_byte(word[8*k +: 8], v.gaps);
      end
    end
    send_byte(v.corrupt ? (cs ^ 8'h01) : cs, v.gaps);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_writes"},   64'(wr_cnt - wr0),   64'(v.n));
    check({tag, "_done"},     64'(done_cnt - dn0), {63'd0, v.exp_done});
    check({tag, "_err"},      64'(err_cnt - er0),  {63'd0, v.exp_err});
    check({tag, "_hold"},     {63'd0, cpu_hold},   {63'd0, v.exp_hold});
    check({tag, "_sb_empty"}, 64'(exp_q.size()),   64'd0);
    // full-rate frame spans 3+5N accept/write edges, first edge inclusive
    if (v.exp_done && !v.gaps)
      check({tag, "_latency"}, 64'(done_cyc - t0), 64'(2 + 5 * v.n));
  endtask

  vec_t vecs[6];

  initial begin
    int wr0, er0;
    vecs[0] = '{n: 1, words: {32'h0, 32'h0, 32'h0, 32'h05031000}, corrupt: 0, gaps: 0,
                exp_done: 1, exp_err: 0, exp_hold: 0};
    vecs[1] = '{n: 3, words: {32'h0, 32'h1502F800, 32'h0901F000, 32'h00430800}, corrupt: 0, gaps: 0,
                exp_done: 1, exp_err: 0, exp_hold: 0};
    vecs[2] = '{n: 3, words: {32'h0, 32'h1502F800, 32'h0901F000, 32'h00430800}, corrupt: 1, gaps: 0,
                exp_done: 0, exp_err: 1, exp_hold: 1};
    vecs[3] = '{n: 0, words: {32'h0, 32'h0, 32'h0, 32'h0}, corrupt: 0, gaps: 0,
                exp_done: 1, exp_err: 0, exp_hold: 0};
    vecs[4] = '{n: 2, words: {32'h0, 32'h0, 32'h01234567, 32'hDEADBEEF}, corrupt: 0, gaps: 1,
                exp_done: 1, exp_err: 0, exp_hold: 0};
    vecs[5] = '{n: 2, words: {32'h0, 32'h0, 32'h01234567, 32'hDEADBEEF}, corrupt: 0, gaps: 0,
                exp_done: 1, exp_err: 0, exp_hold: 0};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_mem_wen",   {63'd0, mem_wen},   64'd0);
    check("rst_mem_addr",  {32'd0, mem_addr},  64'd0);
    check("rst_mem_data",  {32'd0, mem_data},  64'd0);
    check("rst_cpu_hold",  {63'd0, cpu_hold},  64'd1);
    check("rst_load_done", {63'd0, load_done}, 64'd0);
    check("rst_load_err",  {63'd0, load_err},  64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // oversized header: 0x0401 words > 1024 available
    wr0 = wr_cnt; er0 = err_cnt;
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check("oversize_err_pulse", {63'd0, load_err}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("oversize_err_count", 64'(err_cnt - er0), 64'd1);
    check("oversize_no_write",  64'(wr_cnt - wr0),  64'd0);
    check("oversize_hold",      {63'd0, cpu_hold},  64'd1);
    run_vec(vecs[0], "after_oversize");

    // reset in the middle of a word, partial word must not reach memory
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    check("midrst_mem_wen",   {63'd0, mem_wen},   64'd0);
    check("midrst_mem_addr",  {32'd0, mem_addr},  64'd0);
    check("midrst_mem_data",  {32'd0, mem_data},  64'd0);
    check("midrst_cpu_hold",  {63'd0, cpu_hold},  64'd1);
    check("midrst_load_done", {63'd0, load_done}, 64'd0);
    check("midrst_load_err",  {63'd0, load_err},  64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_vec(vecs[1], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes instruction/data words into the single-port `memory` block through its write port (`wen`/`addr`/`data_in`). It receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words and issues one single-cycle write per word at consecutive word addresses. It verifies a trailing XOR checksum and holds the core in stall until a good frame has been loaded. It sits between the host/debug byte link and the memory write port, replacing reset-time hard-coded initialisation.

## Interface
- `ASIZE`, default 32: memory address width (word address).
- `DSIZE`, default 32: memory data width; fixed at 32, matching 4 bytes per word.
- `BASE_ADDR`, default 0: word address of the first written word.
- `MEM_WORDS`, default 1024: memory depth in words (32*ISIZE).
- `clk`  in  1: single clock; all state changes on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: byte on `in_data` is valid.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts byte this cycle.
- `mem_wen`  out  1: write strobe to memory `wen`.
- `mem_addr`  out  ASIZE: to memory `addr`.
- `mem_data`  out  DSIZE: to memory `data_in`.
- `cpu_hold`  out  1: core stall request.
- `load_done`  out  1: one-cycle pulse, frame loaded with good checksum.
- `load_err`  out  1: one-cycle pulse, length or checksum error.

## Operation
- Frame: LEN_HI, LEN_LO (N = 16-bit word count, big-endian), then 4*N payload bytes (each word MSB first), then 1 checksum byte = XOR of both header bytes and all payload bytes.
- Byte transfer occurs on a posedge where `in_valid && in_ready`.
- FSM states: S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM.
  - S_LEN_HI: accept byte -> S_LEN_LO; assert `cpu_hold`.
  - S_LEN_LO: accept byte; if N > MEM_WORDS - BASE_ADDR -> pulse `load_err`, -> S_LEN_HI; else if N == 0 -> S_CSUM; else -> S_DATA.
  - S_DATA: shift byte into word register; byte counter 0..3; after 4th byte -> S_WRITE.
  - S_WRITE: `in_ready`=0; `mem_wen`=1 for exactly this cycle; word counter++; address++; -> S_DATA if words remain, else S_CSUM.
  - S_CSUM: accept byte; match -> pulse `load_done`, clear `cpu_hold`; mismatch -> pulse `load_err`, `cpu_hold` stays 1; both -> S_LEN_HI.
- `in_ready` = 1 in every state except S_WRITE.
- Running checksum is cleared on entry to S_LEN_HI and XORs every accepted byte except the checksum byte.
- Words already written are not rolled back on error.
- `mem_addr` starts at BASE_ADDR for each frame; word address, increments by 1; never exceeds BASE_ADDR+N-1.

## Timing
- Reset values: state S_LEN_HI, `in_ready`=1, `mem_wen`=0, `mem_addr`=BASE_ADDR, `mem_data`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0, counters and checksum 0.
- `mem_addr`/`mem_data` are registered and stable during the `mem_wen` cycle; memory captures on that cycle's posedge.
- Latency: the 4th byte of a word is accepted at edge k; `mem_wen` is high in cycle k+1. The next byte can be accepted no earlier than edge k+2.
- Minimum frame time: 3 + 5N cycles at full `in_valid`.
- `load_done`/`load_err` are high for exactly the cycle after the checksum or LEN_LO acceptance edge.
- `cpu_hold` rises in the cycle after the first LEN_HI byte is accepted, even after a prior good load.
- `in_valid` low at any point: the FSM waits with no timeout. S_WRITE completes regardless of `in_valid`.
- `rst` mid-frame: all outputs return to reset values on the next edge. A partially written image remains in memory, and `cpu_hold`=1.

## Test plan
- Frame 00 01 05 03 10 00 17 -> one `mem_wen` cycle with addr 0 and data 0x05031000, then `load_done` pulse, `cpu_hold` 0.
- Frame N=3 (words 0x00430800, 0x0901F000, 0x1502F800) with correct checksum and continuous `in_valid` -> writes to addr 0,1,2; `in_ready` low exactly on each write cycle; 18 cycles from first byte to `load_done`.
- Same frame with the checksum bit-flipped -> 3 writes still occur, `load_err` pulses, `cpu_hold` stays 1.
- Header N=0x0401 with MEM_WORDS=1024 -> `load_err` after LEN_LO, no `mem_wen`, FSM back in S_LEN_HI.
- N=0 frame 00 00 00 -> `load_done`, no writes. Random `in_valid` gaps on a 2-word frame -> identical writes and status.
- `rst` asserted after 2 payload bytes -> next cycle all outputs at reset values, `mem_addr`=BASE_ADDR; a following good frame loads normally.
